// File: rtl/instruc_decode_pkg.sv
// Shared constants and decode record for the 16-bit MIPS-Lite instruction decoder.
package instruc_decode_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_ANDI  = 4'h4;
  localparam logic [3:0] OP_ORI   = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned RS_MSB    = 11;
  localparam int unsigned RS_LSB    = 9;
  localparam int unsigned RT_MSB    = 8;
  localparam int unsigned RT_LSB    = 6;
  localparam int unsigned RD_MSB    = 5;
  localparam int unsigned RD_LSB    = 3;
  localparam int unsigned FUNCT_MSB = 2;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 5;
  localparam int unsigned IMM_LSB   = 0;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       reg_src;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [5:0] imm;
    logic       undef;
  } dec_t;

endpackage

// File: rtl/instruc_decode_comb.sv
// Purely combinational opcode/field decoder; undefined opcodes decode as a NOP.
module instruc_decode_comb
  import instruc_decode_pkg::*;
(
  input  logic [15:0] instruc,
  output dec_t        dec
);

  logic [3:0] opcode;

  always_comb begin
    opcode        = instruc[OPC_MSB:OPC_LSB];
    dec           = '0;
    dec.rs        = instruc[RS_MSB:RS_LSB];
    dec.rt        = instruc[RT_MSB:RT_LSB];
    dec.imm       = instruc[IMM_MSB:IMM_LSB];
    // I-type instructions write back to the Rt field
    dec.rd        = instruc[RT_MSB:RT_LSB];
    dec.alu_op    = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec.alu_op    = instruc[FUNCT_MSB:FUNCT_LSB];
        dec.rd        = instruc[RD_MSB:RD_LSB];
        dec.reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_src   = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_op    = ALU_AND;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ORI: begin
        dec.alu_op    = ALU_OR;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec.undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruc_decode.sv
// Registered instruction decoder: one-cycle latency, strobes gated by instruc_valid.
// Define INSTRUC_DECODE_ILLEGAL_EN to flag undefined opcodes on the illegal output.
module instruc_decode
  import instruc_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruc,
  input  logic        instruc_valid,
  output logic        dec_valid,
  output logic [2:0]  ALU_op,
  output logic        ALU_src_cntrl,
  output logic        Reg_write,
  output logic        Mem_write,
  output logic        Reg_src_cntrl,
  output logic [2:0]  Rs,
  output logic [2:0]  Rt,
  output logic [2:0]  Rd,
  output logic [5:0]  Imm_Add,
  output logic        illegal
);

`ifdef INSTRUC_DECODE_ILLEGAL_EN
  localparam logic ILLEGAL_EN = 1'b1;
`else
  localparam logic ILLEGAL_EN = 1'b0;
`endif

  dec_t dec;

  instruc_decode_comb u_comb (
    .instruc (instruc),
    .dec     (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_valid     <= 1'b0;
      ALU_op        <= '0;
      ALU_src_cntrl <= 1'b0;
      Reg_write     <= 1'b0;
      Mem_write     <= 1'b0;
      Reg_src_cntrl <= 1'b0;
      Rs            <= '0;
      Rt            <= '0;
      Rd            <= '0;
      Imm_Add       <= '0;
      illegal       <= 1'b0;
    end else begin
      dec_valid     <= instruc_valid;
      ALU_op        <= dec.alu_op;
      ALU_src_cntrl <= dec.alu_src;
      Reg_write     <= dec.reg_write & instruc_valid;
      Mem_write     <= dec.mem_write & instruc_valid;
      Reg_src_cntrl <= dec.reg_src;
      Rs            <= dec.rs;
      Rt            <= dec.rt;
      Rd            <= dec.rd;
      Imm_Add       <= dec.imm;
      // Constant-folds to a tied-off 0 when the flag is disabled
      illegal       <= dec.undef & instruc_valid & ILLEGAL_EN;
    end
  end

endmodule

// File: tb/tb_instruc_decode.sv
// Self-checking bench for instruc_decode: directed ISA vectors, random stream, mid-stream reset.
module tb_instruc_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instruc;
  logic        instruc_valid;
  logic        dec_valid;
  logic [2:0]  ALU_op;
  logic        ALU_src_cntrl;
  logic        Reg_write;
  logic        Mem_write;
  logic        Reg_src_cntrl;
  logic [2:0]  Rs;
  logic [2:0]  Rt;
  logic [2:0]  Rd;
  logic [5:0]  Imm_Add;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

`ifdef INSTRUC_DECODE_ILLEGAL_EN
  localparam int ILL_EN = 1;
`else
  localparam int ILL_EN = 0;
`endif

  typedef struct {
    int valid, alu, src, rw, mw, rsrc, rs, rt, rd, imm, ill;
  } exp_t;

  instruc_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruc       (instruc),
    .instruc_valid (instruc_valid),
    .dec_valid     (dec_valid),
    .ALU_op        (ALU_op),
    .ALU_src_cntrl (ALU_src_cntrl),
    .Reg_write     (Reg_write),
    .Mem_write     (Mem_write),
    .Reg_src_cntrl (Reg_src_cntrl),
    .Rs            (Rs),
    .Rt            (Rt),
    .Rd            (Rd),
    .Imm_Add       (Imm_Add),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  // Reference: table lookup on the opcode number, fields extracted arithmetically
  function automatic exp_t model(input int w, input int v);
    exp_t e;
    int op;
    op      = w / 4096;
    e.valid = v;
    e.rs    = (w / 512) % 8;
    e.rt    = (w / 64) % 8;
    e.imm   = w % 64;
    e.rd    = e.rt;
    e.alu = 0; e.src = 0; e.rw = 0; e.mw = 0; e.rsrc = 0; e.ill = 0;
    case (op)
      0: begin e.alu = w % 8; e.rw = 1; e.rd = (w / 8) % 8; end
      1: begin e.src = 1; e.rw = 1; end
      2: begin e.src = 1; e.rw = 1; e.rsrc = 1; end
      3: begin e.src = 1; e.mw = 1; end
      4: begin e.alu = 2; e.src = 1; e.rw = 1; end
      5: begin e.alu = 3; e.src = 1; e.rw = 1; end
      default: e.ill = ILL_EN;
    endcase
    if (v == 0) begin e.rw = 0; e.mw = 0; e.ill = 0; end
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ctx, input exp_t e);
    chk({ctx, ".dec_valid"},     16'(dec_valid),     16'(e.valid));
    chk({ctx, ".ALU_op"},        16'(ALU_op),        16'(e.alu));
    chk({ctx, ".ALU_src_cntrl"}, 16'(ALU_src_cntrl), 16'(e.src));
    chk({ctx, ".Reg_write"},     16'(Reg_write),     16'(e.rw));
    chk({ctx, ".Mem_write"},     16'(Mem_write),     16'(e.mw));
    chk({ctx, ".Reg_src_cntrl"}, 16'(Reg_src_cntrl), 16'(e.rsrc));
    chk({ctx, ".Rs"},            16'(Rs),            16'(e.rs));
    chk({ctx, ".Rt"},            16'(Rt),            16'(e.rt));
    chk({ctx, ".Rd"},            16'(Rd),            16'(e.rd));
    chk({ctx, ".Imm_Add"},       16'(Imm_Add),       16'(e.imm));
    chk({ctx, ".illegal"},       16'(illegal),       16'(e.ill));
  endtask

  task automatic apply(input string ctx, input logic [15:0] w, input logic v);
    @(negedge clk);
    instruc       = w;
    instruc_valid = v;
    @(posedge clk);
    #1;
    chk_all(ctx, model(int'(w), int'(v)));
  endtask

  initial begin
    logic [15:0] w;
    logic        v;
    rst_n         = 1'b0;
    instruc       = 16'hFFFF;
    instruc_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", zero_exp());

    @(negedge clk);
    rst_n = 1'b1;
    apply("nop_r0",   16'h0000, 1'b1);
    apply("sub",      16'h0299, 1'b1);
    apply("lw",       16'h2547, 1'b1);
    apply("sw",       16'h32FF, 1'b1);
    apply("addi",     16'h1ABC, 1'b1);
    apply("andi",     16'h4E2D, 1'b1);
    apply("ori",      16'h5F01, 1'b1);
    apply("undef",    16'hF000, 1'b1);
    apply("undef6",   16'h6FFF, 1'b1);
    apply("undef_nv", 16'hF000, 1'b0);
    apply("sw_nv",    16'h3FFF, 1'b0);
    apply("srl",      16'h0FFF, 1'b1);

    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      v = 1'($urandom_range(0, 3) != 0);
      apply("rand", w, v);
    end

    // Reset while a valid instruction is in flight
    @(negedge clk);
    instruc       = 16'h2547;
    instruc_valid = 1'b1;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    chk_all("midreset", zero_exp());
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset", 16'h0000, 1'b1);
    apply("post_reset2", 16'h1234, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruc_decode.md
# instruc_decode

Registered instruction decoder for the 16-bit MIPS-Lite core. It sits between instruction fetch and the register file / ALU. It splits each instruction into register-specifier and immediate fields, and produces the ALU operation code plus datapath control strobes (ALU operand select, register write, memory write, write-back source). All outputs are registered with one cycle of latency.

## Interface
One clock; reset is synchronous and active-low.

Parameters:
- None. Field widths are fixed by the ISA.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instruc  in  16  instruction word
- instruc_valid  in  1  instruc holds a real instruction this cycle
- dec_valid  out  1  decoded outputs are valid (instruc_valid delayed one cycle)
- ALU_op  out  3  ALU operation code
- ALU_src_cntrl  out  1  0 = second ALU operand is register Rt; 1 = Imm_Add
- Reg_write  out  1  register-file write enable
- Mem_write  out  1  data-memory write enable
- Reg_src_cntrl  out  1  write-back source: 0 = ALU result; 1 = memory read data
- Rs  out  3  source register 1
- Rt  out  3  source register 2
- Rd  out  3  destination register
- Imm_Add  out  6  raw 6-bit immediate / address offset; no extension is done here
- illegal  out  1  undefined opcode flag (see Configuration)

## Operation
Field layout:
- opcode = instruc[15:12]
- Rs = [11:9]
- Rt = [8:6]
- R-type Rd field = [5:3]
- funct = [2:0]
- Imm_Add = [5:0]

Rs, Rt and Imm_Add are always driven from their bit positions, regardless of opcode.

Rd is the write destination:
- R-type: instruc[5:3]
- All I-type: instruc[8:6]

Opcode table (ALU_op / ALU_src_cntrl / Reg_write / Mem_write / Reg_src_cntrl):
- 0000 R-type: ALU_op = funct / 0 / 1 / 0 / 0
- 0001 ADDI: ADD / 1 / 1 / 0 / 0
- 0010 LW: ADD / 1 / 1 / 0 / 1
- 0011 SW: ADD / 1 / 0 / 1 / 0
- 0100 ANDI: AND / 1 / 1 / 0 / 0
- 0101 ORI: OR / 1 / 1 / 0 / 0
- 0110–1111 undefined: ADD / 0 / 0 / 0 / 0, i.e. a NOP

ALU_op codes: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.

Gating:
- When instruc_valid = 0, the registered Reg_write, Mem_write and illegal are 0.
- The fields and ALU_op still update; they are don't-care to consumers.

## Timing
- All outputs are registered. The decode of the instruc sampled at edge N appears after edge N, with a latency of 1 cycle.
- There is no stall or backpressure; a new instruction can be accepted every cycle.
- Reset: when rst_n = 0 at a rising edge, every output goes to 0 on that edge, including dec_valid, ALU_op = 000 and all fields.
- Reset mid-stream: the in-flight decode is discarded. The first valid output appears one cycle after the first valid instruction following rst_n = 1.
- Back-to-back instructions produce back-to-back outputs with no bubbles.

## Configuration
- Macro `INSTRUC_DECODE_ILLEGAL_EN`.
- Defined: opcodes 0110–1111 with instruc_valid = 1 set illegal = 1 for one cycle, aligned with dec_valid.
- Not defined: the illegal port exists but is tied to 0.
- Undefined opcodes decode as NOP in both cases.

## Structure
- Package `instruc_decode_pkg` holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_ANDI, OP_ORI)
  - ALU_op localparams (ALU_ADD … ALU_SRL)
  - field-position constants
- One sub-module is natural: `instruc_decode_comb`, a purely combinational opcode/field decoder. The top level contains only the output register, valid gating and reset.

## Test plan
- 16'h0000, valid → next cycle: ALU_op = 000, ALU_src_cntrl = 0, Reg_write = 1, Mem_write = 0, Reg_src_cntrl = 0, Rs = Rt = Rd = 0, Imm_Add = 0, dec_valid = 1.
- 16'h0299 (SUB r3 = r1 − r2) → ALU_op = 001, Rs = 1, Rt = 2, Rd = 3, Reg_write = 1, ALU_src_cntrl = 0.
- 16'h2547 (LW) → Rs = 2, Rt = 5, Rd = 5, Imm_Add = 7, ALU_op = 000, ALU_src_cntrl = 1, Reg_write = 1, Reg_src_cntrl = 1, Mem_write = 0.
- 16'h32FF (SW) → Rs = 1, Rt = 3, Imm_Add = 6'h3F, Mem_write = 1, Reg_write = 0, ALU_src_cntrl = 1.
- 16'hF000, valid → Reg_write = Mem_write = 0; illegal = 1 only with the macro defined. The same word with instruc_valid = 0 gives illegal = 0 and dec_valid = 0.
- Valid stream, then rst_n = 0 for one edge → all outputs 0 on that edge. A valid 16'h0000 applied with rst_n = 1 gives dec_valid = 1 one cycle later.
